// File: rtl/md_ctl_pkg.sv
// Shared types for the MD timestep control path: sequencer states, phase IDs,
// and the state-to-phase mapping used to time-share the handshake block.
package md_ctl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_P1_GO,
    ST_P1_WAIT,
    ST_P2_GO,
    ST_P2_WAIT,
    ST_P3_GO,
    ST_P3_WAIT,
    ST_SWAP,
    ST_ERROR
  } state_e;

  typedef enum logic [1:0] {
    PH_NONE  = 2'd0,
    PH_FORCE = 2'd1,
    PH_VEL   = 2'd2,
    PH_POS   = 2'd3
  } phase_e;

  function automatic phase_e phase_of(input state_e s);
    case (s)
      ST_P1_GO, ST_P1_WAIT: return PH_FORCE;
      ST_P2_GO, ST_P2_WAIT: return PH_VEL;
      ST_P3_GO, ST_P3_WAIT: return PH_POS;
      default:              return PH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/phase_handshake.sv
// Ready pulse, done rising-edge detect and watchdog for whichever phase is
// currently selected by the sequencer.
module phase_handshake #(
  parameter int unsigned WD_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic go_i,
  input  logic wait_i,
  input  logic done_i,
  output logic ready_o,
  output logic done_edge_o,
  output logic timeout_o
);

  localparam int unsigned WD_W = (WD_CYCLES > 1) ? $clog2(WD_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((WD_CYCLES == 0) ? 0 : WD_CYCLES - 1);

  logic            prev_q;
  logic [WD_W-1:0] wd_q;

  // prev tracks the selected done every cycle, so in the GO cycle it captures
  // the new phase's level and a held-high done can never look like an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
      wd_q   <= '0;
    end else begin
      prev_q <= done_i;
      if (go_i)
        wd_q <= '0;
      else if (wait_i && (WD_CYCLES != 0))
        wd_q <= wd_q + 1'b1;
    end
  end

  always_comb begin
    ready_o     = go_i;
    done_edge_o = wait_i && done_i && !prev_q;
    timeout_o   = (WD_CYCLES != 0) && wait_i && (wd_q == WD_LAST);
  end

endmodule

// File: rtl/timestep_controller.sv
// Sequences force, velocity and position phases for each MD timestep, flips
// the double buffer per step and stops at the programmed step limit.
module timestep_controller
  import md_ctl_pkg::*;
#(
  parameter int unsigned STEP_W    = 32,
  parameter int unsigned WD_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [STEP_W-1:0] n_steps,
  input  logic              p1_done,
  input  logic              p2_done,
  input  logic              p3_done,
  output logic              p1_ready,
  output logic              p2_ready,
  output logic              p3_ready,
  output logic              double_buffer,
  output logic              busy,
  output logic [STEP_W-1:0] step_count,
  output logic              run_done,
  output logic [1:0]        error
);

  state_e            state_q, state_d;
  phase_e            err_q, err_d;
  logic [STEP_W-1:0] limit_q, limit_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              dbuf_q, dbuf_d;
  logic              run_done_q, run_done_d;

  phase_e phase;
  logic   go, waiting, done_sel, hs_ready, done_edge, timeout;

  always_comb begin
    phase   = phase_of(state_q);
    go      = state_q inside {ST_P1_GO, ST_P2_GO, ST_P3_GO};
    waiting = state_q inside {ST_P1_WAIT, ST_P2_WAIT, ST_P3_WAIT};
    case (phase)
      PH_FORCE: done_sel = p1_done;
      PH_VEL:   done_sel = p2_done;
      PH_POS:   done_sel = p3_done;
      default:  done_sel = 1'b0;
    endcase
  end

  phase_handshake #(
    .WD_CYCLES(WD_CYCLES)
  ) u_hs (
    .clk_i      (clk),
    .rst_i      (reset),
    .go_i       (go),
    .wait_i     (waiting),
    .done_i     (done_sel),
    .ready_o    (hs_ready),
    .done_edge_o(done_edge),
    .timeout_o  (timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      err_q      <= PH_NONE;
      limit_q    <= '0;
      step_q     <= '0;
      dbuf_q     <= 1'b0;
      run_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      limit_q    <= limit_d;
      step_q     <= step_d;
      dbuf_q     <= dbuf_d;
      run_done_q <= run_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    limit_d    = limit_q;
    step_d     = step_q;
    dbuf_d     = dbuf_q;
    run_done_d = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_ERROR: begin
          if (start) begin
            err_d = PH_NONE;
            if (n_steps != '0) begin
              limit_d = n_steps;
              step_d  = '0;
              state_d = ST_P1_GO;
            end else begin
              run_done_d = 1'b1;
              state_d    = ST_IDLE;
            end
          end
        end
        ST_P1_GO: state_d = ST_P1_WAIT;
        ST_P2_GO: state_d = ST_P2_WAIT;
        ST_P3_GO: state_d = ST_P3_WAIT;
        // A done edge coinciding with watchdog expiry is taken as success.
        ST_P1_WAIT: begin
          if (done_edge) state_d = ST_P2_GO;
          else if (timeout) begin err_d = phase; state_d = ST_ERROR; end
        end
        ST_P2_WAIT: begin
          if (done_edge) state_d = ST_P3_GO;
          else if (timeout) begin err_d = phase; state_d = ST_ERROR; end
        end
        ST_P3_WAIT: begin
          if (done_edge) state_d = ST_SWAP;
          else if (timeout) begin err_d = phase; state_d = ST_ERROR; end
        end
        ST_SWAP: begin
          dbuf_d = ~dbuf_q;
          step_d = step_q + 1'b1;
          if (step_d == limit_q) begin
            run_done_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_P1_GO;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    p1_ready      = hs_ready && (phase == PH_FORCE);
    p2_ready      = hs_ready && (phase == PH_VEL);
    p3_ready      = hs_ready && (phase == PH_POS);
    busy          = !(state_q inside {ST_IDLE, ST_ERROR});
    double_buffer = dbuf_q;
    step_count    = step_q;
    run_done      = run_done_q;
    error         = err_q;
  end

endmodule

// File: tb/tb_timestep_controller.sv
// Directed bench for timestep_controller with an 8-bit step count and a
// 16-cycle watchdog.
module tb_timestep_controller;

  logic       clk, reset, start, abort;
  logic [7:0] n_steps;
  logic [2:0] done_v;
  logic       p1_ready, p2_ready, p3_ready, double_buffer, busy, run_done;
  logic [7:0] step_count;
  logic [1:0] error;

  int n_checks = 0;
  int n_pass   = 0;
  logic exp_db = 1'b0;

  timestep_controller #(
    .STEP_W   (8),
    .WD_CYCLES(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .n_steps      (n_steps),
    .p1_done      (done_v[0]),
    .p2_done      (done_v[1]),
    .p3_done      (done_v[2]),
    .p1_ready     (p1_ready),
    .p2_ready     (p2_ready),
    .p3_ready     (p3_ready),
    .double_buffer(double_buffer),
    .busy         (busy),
    .step_count   (step_count),
    .run_done     (run_done),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {p3,p2,p1 ready, busy, double_buffer, run_done, error, step_count}
  function automatic logic [15:0] snap();
    return {p3_ready, p2_ready, p1_ready, busy, double_buffer, run_done, error, step_count};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one phase from its GO cycle to the next state with an immediate done edge.
  task automatic advance(input int ph);
    tick();
    done_v[ph] = 1'b1;
    tick();
    done_v[ph] = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] n);
    n_steps = n;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_checks++;
    if (snap() !== 16'h0000) $display("FAIL reset_outputs: got %h expected %h", snap(), 16'h0000);
    else n_pass++;
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    n_checks++;
    if (snap() !== 16'h0000) $display("FAIL reset_idle: got %h expected %h", snap(), 16'h0000);
    else n_pass++;
  endtask

  task automatic test_three_steps();
    logic [15:0] exp;
    bit stray;
    do_start(8'd3);
    for (int s = 0; s < 3; s++) begin
      for (int ph = 0; ph < 3; ph++) begin
        exp = {3'b001 << ph, 1'b1, exp_db, 1'b0, 2'd0, 8'(s)};
        n_checks++;
        if (snap() !== exp) $display("FAIL go_s%0d_p%0d: got %h expected %h", s, ph + 1, snap(), exp);
        else n_pass++;
        stray = 1'b0;
        for (int i = 1; i < 10; i++) begin
          tick();
          if (snap() !== {3'b000, 1'b1, exp_db, 1'b0, 2'd0, 8'(s)}) stray = 1'b1;
        end
        tick();
        done_v[ph] = 1'b1;
        tick();
        done_v[ph] = 1'b0;
        n_checks++;
        if (stray !== 1'b0) $display("FAIL wait_s%0d_p%0d: got stray=%0b expected 0", s, ph + 1, stray);
        else n_pass++;
        if (ph == 2) begin
          exp = {3'b000, 1'b1, exp_db, 1'b0, 2'd0, 8'(s)};
          n_checks++;
          if (snap() !== exp) $display("FAIL swap_s%0d: got %h expected %h", s, snap(), exp);
          else n_pass++;
          tick();
          exp_db = ~exp_db;
        end
      end
    end
    exp = {3'b000, 1'b0, exp_db, 1'b1, 2'd0, 8'd3};
    n_checks++;
    if (snap() !== exp) $display("FAIL run_end: got %h expected %h", snap(), exp);
    else n_pass++;
    tick();
    exp = {3'b000, 1'b0, exp_db, 1'b0, 2'd0, 8'd3};
    n_checks++;
    if (snap() !== exp) $display("FAIL run_done_single: got %h expected %h", snap(), exp);
    else n_pass++;
  endtask

  task automatic test_zero_steps();
    bit stray;
    do_start(8'd0);
    n_checks++;
    if ({run_done, busy, p3_ready, p2_ready, p1_ready} !== 5'b10000)
      $display("FAIL zero_run_done: got %b expected %b", {run_done, busy, p3_ready, p2_ready, p1_ready}, 5'b10000);
    else n_pass++;
    stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if ({run_done, busy, p3_ready, p2_ready, p1_ready} !== 5'b00000) stray = 1'b1;
    end
    n_checks++;
    if (stray !== 1'b0) $display("FAIL zero_quiet: got stray=%0b expected 0", stray);
    else n_pass++;
  endtask

  task automatic test_held_done();
    bit stray;
    logic [15:0] exp;
    done_v[0] = 1'b1;
    do_start(8'd1);
    n_checks++;
    if ({p3_ready, p2_ready, p1_ready} !== 3'b001) $display("FAIL held_go1: got %b expected 001", {p3_ready, p2_ready, p1_ready});
    else n_pass++;
    stray = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({p3_ready, p2_ready, p1_ready, busy} !== 4'b0001) stray = 1'b1;
    end
    done_v[0] = 1'b0;
    tick(); tick();
    if ({p3_ready, p2_ready, p1_ready, busy} !== 4'b0001) stray = 1'b1;
    n_checks++;
    if (stray !== 1'b0) $display("FAIL held_no_advance: got stray=%0b expected 0", stray);
    else n_pass++;
    done_v[0] = 1'b1;
    tick();
    done_v[0] = 1'b0;
    n_checks++;
    if ({p3_ready, p2_ready, p1_ready} !== 3'b010) $display("FAIL held_go2: got %b expected 010", {p3_ready, p2_ready, p1_ready});
    else n_pass++;
    advance(1);
    n_checks++;
    if ({p3_ready, p2_ready, p1_ready} !== 3'b100) $display("FAIL held_single_p2: got %b expected 100", {p3_ready, p2_ready, p1_ready});
    else n_pass++;
    advance(2);
    tick();
    exp_db = ~exp_db;
    exp = {3'b000, 1'b0, exp_db, 1'b1, 2'd0, 8'd1};
    n_checks++;
    if (snap() !== exp) $display("FAIL held_end: got %h expected %h", snap(), exp);
    else n_pass++;
  endtask

  task automatic test_watchdog();
    logic [15:0] exp;
    do_start(8'd1);
    advance(0);
    n_checks++;
    if ({p3_ready, p2_ready, p1_ready} !== 3'b010) $display("FAIL wd_go2: got %b expected 010", {p3_ready, p2_ready, p1_ready});
    else n_pass++;
    for (int i = 0; i < 16; i++) tick();
    n_checks++;
    if ({error, busy} !== 3'b001) $display("FAIL wd_cycle16: got %b expected 001", {error, busy});
    else n_pass++;
    tick();
    exp = {3'b000, 1'b0, exp_db, 1'b0, 2'd2, 8'd0};
    n_checks++;
    if (snap() !== exp) $display("FAIL wd_error: got %h expected %h", snap(), exp);
    else n_pass++;
    tick(); tick();
    n_checks++;
    if (snap() !== exp) $display("FAIL wd_sticky: got %h expected %h", snap(), exp);
    else n_pass++;
    do_start(8'd1);
    exp = {3'b001, 1'b1, exp_db, 1'b0, 2'd0, 8'd0};
    n_checks++;
    if (snap() !== exp) $display("FAIL wd_restart: got %h expected %h", snap(), exp);
    else n_pass++;
    for (int i = 0; i < 16; i++) tick();
    done_v[0] = 1'b1;
    tick();
    done_v[0] = 1'b0;
    exp = {3'b010, 1'b1, exp_db, 1'b0, 2'd0, 8'd0};
    n_checks++;
    if (snap() !== exp) $display("FAIL wd_edge_wins: got %h expected %h", snap(), exp);
    else n_pass++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if ({busy, p3_ready, p2_ready, p1_ready} !== 4'b0000) $display("FAIL wd_cleanup: got %b expected 0000", {busy, p3_ready, p2_ready, p1_ready});
    else n_pass++;
  endtask

  task automatic test_abort();
    logic [15:0] exp;
    do_start(8'd2);
    advance(0); advance(1); advance(2);
    tick();
    exp_db = ~exp_db;
    exp = {3'b001, 1'b1, exp_db, 1'b0, 2'd0, 8'd1};
    n_checks++;
    if (snap() !== exp) $display("FAIL abort_step1: got %h expected %h", snap(), exp);
    else n_pass++;
    advance(0); advance(1);
    tick();
    done_v[2] = 1'b1;
    abort     = 1'b1;
    tick();
    done_v[2] = 1'b0;
    abort     = 1'b0;
    exp = {3'b000, 1'b0, exp_db, 1'b0, 2'd0, 8'd1};
    n_checks++;
    if (snap() !== exp) $display("FAIL abort_idle: got %h expected %h", snap(), exp);
    else n_pass++;
    tick(); tick();
    n_checks++;
    if (snap() !== exp) $display("FAIL abort_hold: got %h expected %h", snap(), exp);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    bit stray;
    do_start(8'd3);
    advance(0);
    tick();
    #3;
    reset = 1'b1;
    #1;
    n_checks++;
    if (snap() !== 16'h0000) $display("FAIL midreset_async: got %h expected %h", snap(), 16'h0000);
    else n_pass++;
    exp_db = 1'b0;
    tick();
    reset = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (snap() !== 16'h0000) stray = 1'b1;
    end
    n_checks++;
    if (stray !== 1'b0) $display("FAIL midreset_stay_idle: got stray=%0b expected 0", stray);
    else n_pass++;
    do_start(8'd1);
    n_checks++;
    if (snap() !== {3'b001, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0})
      $display("FAIL midreset_restart: got %h expected %h", snap(), {3'b001, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0});
    else n_pass++;
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    n_steps = '0;
    done_v  = '0;
    #1;
    test_reset();
    test_three_steps();
    test_zero_steps();
    test_held_done();
    test_watchdog();
    test_abort();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
